// File: rtl/uart_pkg.sv
// Shared UART receive-path types and default sizing.
package uart_pkg;

  localparam int unsigned UART_RX_FIFO_DEPTH     = 16;
  localparam int unsigned UART_RX_FIFO_WATERMARK = 12;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/counter.sv
// Wrap-around up-counter with synchronous load (load has priority over enable).
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_en) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_fifo_mem.sv
// Dual-port entry array with a registered read port that doubles as the FWFT head register.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  rx_entry_t                i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output rx_entry_t                o_rd_data
);

  rx_entry_t r_mem [DEPTH];
  rx_entry_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Write-first bypass: a byte pushed into the slot that becomes the head shows up next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the host: FWFT output, framing tags,
// sticky overrun and a watermark flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH,
  parameter int unsigned WATERMARK = UART_RX_FIFO_WATERMARK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_valid,
  input  logic                   framing_err,
  input  logic                   overrun,
  output logic                   host_ready,
  output logic                   clear_framing_err,
  output logic [7:0]             out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clear_overrun,
  output logic                   overrun_sticky,
  output logic [$clog2(DEPTH):0] level,
  output logic                   level_hit
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [LW-1:0] LevelMark = LW'(WATERMARK);

  logic [LW-1:0] r_level;
  logic          r_out_valid;
  logic          r_level_hit;
  logic          r_overrun_sticky;
  logic          r_clear_framing_err;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [LW-1:0] w_level_nxt;
  rx_entry_t     w_wr_entry;
  rx_entry_t     w_head;

  assign host_ready = (r_level != LevelFull) & ~flush;
  assign w_push     = rx_data_valid & host_ready;
  assign w_pop      = r_out_valid & out_ready & ~flush;

  counter #(
    .WIDTH (AW)
  ) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (flush),
    .i_d    ('0),
    .i_en   (w_push),
    .o_q    (w_wr_ptr)
  );

  counter #(
    .WIDTH (AW)
  ) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (flush),
    .i_d    ('0),
    .i_en   (w_pop),
    .o_q    (w_rd_ptr)
  );

  // The head register reads ahead at the pointer value the read counter will hold next cycle.
  always_comb begin
    w_rd_ptr_nxt = w_rd_ptr;
    if (flush) begin
      w_rd_ptr_nxt = '0;
    end else if (w_pop) begin
      w_rd_ptr_nxt = w_rd_ptr + AW'(1);
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  assign w_wr_entry.err  = framing_err;
  assign w_wr_entry.data = rx_data;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_addr (w_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (w_rd_ptr_nxt),
    .o_rd_data (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level             <= '0;
      r_out_valid         <= 1'b0;
      r_level_hit         <= 1'b0;
      r_overrun_sticky    <= 1'b0;
      r_clear_framing_err <= 1'b0;
    end else begin
      r_level             <= w_level_nxt;
      r_out_valid         <= (w_level_nxt != '0);
      r_level_hit         <= (w_level_nxt >= LevelMark);
      r_clear_framing_err <= w_push & framing_err;
      // Set wins over clear so an overrun coinciding with a clear is never lost.
      if (overrun) begin
        r_overrun_sticky <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun_sticky <= 1'b0;
      end
    end
  end

  assign out_data          = w_head.data;
  assign out_err           = w_head.err;
  assign out_valid         = r_out_valid;
  assign level             = r_level;
  assign level_hit         = r_level_hit;
  assign overrun_sticky    = r_overrun_sticky;
  assign clear_framing_err = r_clear_framing_err;

endmodule
